// File: rtl/seq_tx.sv
// Serial frame transmitter for sequence-detector stimulus: shifts a WIDTH-bit frame
// out on w, alongside the expected detector response z_exp (1 when w repeats the previous bit).
module seq_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             w,
  output logic             w_valid,
  output logic             z_exp,
  output logic             done,
  output logic [2:0]       state
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             prev_q, prev_d;
  logic             w_q, w_d;
  logic             z_q, z_d;
  logic             head_cur, head_nxt;

  function automatic logic head_of(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      w_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      w_q     <= w_d;
      z_q     <= z_d;
    end
  end

  // Next state, datapath update, and look-ahead for the registered w / z_exp
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    head_cur = head_of(sreg_q);
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          sreg_d  = data;
          cnt_d   = '0;
          prev_d  = 1'b0;
        end
      end
      SHIFT: begin
        sreg_d = shift_of(sreg_q);
        cnt_d  = cnt_q + CW'(1);
        prev_d = head_cur;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
        prev_d  = 1'b0;
      end
    endcase
    head_nxt = head_of(sreg_d);
    w_d      = (state_d == SHIFT) && head_nxt;
    z_d      = (state_d == SHIFT) && (cnt_d != '0) && (head_nxt == prev_d);
  end

  assign state   = state_q;
  assign ready   = state_q[0];
  assign w_valid = state_q[1];
  assign done    = state_q[2];
  assign w       = w_q;
  assign z_exp   = z_q;

endmodule

// File: tb/tb_seq_tx.sv
// Directed scoreboard bench for seq_tx: one MSB-first and one LSB-first instance.
module tb_seq_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_m, load_l;
  logic [7:0] data_m, data_l;
  logic       ready_m, w_m, wv_m, z_m, done_m;
  logic       ready_l, w_l, wv_l, z_l, done_l;
  logic [2:0] state_m, state_l;

  int tests = 0;
  int fails = 0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  seq_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .load(load_m), .data(data_m), .ready(ready_m),
    .w(w_m), .w_valid(wv_m), .z_exp(z_m), .done(done_m), .state(state_m));

  seq_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load(load_l), .data(data_l), .ready(ready_l),
    .w(w_l), .w_valid(wv_l), .z_exp(z_l), .done(done_l), .state(state_l));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {w, z_exp} pairs for one frame, built from the bit order alone
  task automatic push_frame(input logic [7:0] d, input bit msb);
    logic b, pb;
    pb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = msb ? d[7 - i] : d[i];
      sb.push_back({b, (i > 0) && (b == pb)});
      pb = b;
    end
  endtask

  // Walks the 8 bit cycles, the done cycle and the ready cycle; optional busy load at bit busy_at
  task automatic collect(input bit sel, input string tag, input int busy_at);
    logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_wvalid"}, sel ? wv_l : wv_m, 1);
      check({tag, "_ready_busy"}, sel ? ready_l : ready_m, 0);
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s_w%0d", tag, i), sel ? w_l : w_m, e[1]);
        check($sformatf("%s_z%0d", tag, i), sel ? z_l : z_m, e[0]);
      end
      if (i == busy_at) begin
        load_m = 1'b1;
        data_m = 8'hFF;
      end
      step();
      load_m = 1'b0;
    end
    check({tag, "_done"}, sel ? done_l : done_m, 1);
    check({tag, "_done_wvalid"}, sel ? wv_l : wv_m, 0);
    check({tag, "_done_w"}, sel ? w_l : w_m, 0);
    step();
    check({tag, "_ready_after"}, sel ? ready_l : ready_m, 1);
    check({tag, "_done_cleared"}, sel ? done_l : done_m, 0);
    check({tag, "_state_after"}, sel ? state_l : state_m, 3'b001);
  endtask

  initial begin
    reset = 1'b0; load_m = 1'b0; load_l = 1'b0; data_m = '0; data_l = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_state", state_m, 3'b001);
    check("rst_ready", ready_m, 1);
    check("rst_w", w_m, 0);
    check("rst_wvalid", wv_m, 0);
    check("rst_z", z_m, 0);
    check("rst_done", done_m, 0);
    check("rst_state_lsb", state_l, 3'b001);

    // Basic MSB-first frame
    push_frame(8'hB4, 1'b1);
    load_m = 1'b1; data_m = 8'hB4;
    step();
    load_m = 1'b0;
    collect(1'b0, "b4", -1);

    // Load while busy must not disturb the stream or queue a second frame
    push_frame(8'hB4, 1'b1);
    load_m = 1'b1; data_m = 8'hB4;
    step();
    load_m = 1'b0;
    collect(1'b0, "busy", 2);
    for (int i = 0; i < 10; i++) begin
      check("busy_no_extra", wv_m, 0);
      step();
    end

    // Reset during the 4th bit drops the frame with no done pulse
    load_m = 1'b1; data_m = 8'hB4;
    step();
    load_m = 1'b0;
    step(); step(); step();
    check("mid_wvalid_pre", wv_m, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_state", state_m, 3'b001);
    check("mid_wvalid", wv_m, 0);
    for (int i = 0; i < 10; i++) begin
      check("mid_no_done", done_m, 0);
      step();
    end
    push_frame(8'h0F, 1'b1);
    load_m = 1'b1; data_m = 8'h0F;
    step();
    load_m = 1'b0;
    collect(1'b0, "f0f", -1);

    // LSB-first frame
    push_frame(8'h01, 1'b0);
    load_l = 1'b1; data_l = 8'h01;
    step();
    load_l = 1'b0;
    collect(1'b1, "lsb", -1);

    // Reset wins over a simultaneous load
    load_m = 1'b1; data_m = 8'hA5; reset = 1'b1;
    step();
    load_m = 1'b0; reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("rl_wvalid", wv_m, 0);
      check("rl_state", state_m, 3'b001);
      step();
    end

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of bits per frame (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends data[WIDTH-1] first, 0 sends data[0] first.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset; one clock; sampled only on the rising edge of clk.
REQ-005 SHALL have port load  input  1  frame request, accepted only when ready=1.
REQ-006 SHALL have port data  input  WIDTH  parallel frame, captured on an accepted load.
REQ-007 SHALL have port ready  output  1  1 when idle and able to accept load.
REQ-008 SHALL have port w  output  1  serial bit stream that drives the sequence detector's w input.
REQ-009 SHALL have port w_valid  output  1  1 during cycles in which w carries a frame bit.
REQ-010 SHALL have port z_exp  output  1  expected detector z for the current bit.
REQ-011 SHALL have port done  output  1  single-cycle pulse after the last bit of a frame.
REQ-012 SHALL have port state  output  3  one-hot state vector {DONE,SHIFT,IDLE}.

Function
REQ-013 SHALL implement a one-hot FSM with states IDLE=001, SHIFT=010 and DONE=100; any other encoding SHALL be illegal and SHALL not be entered.
REQ-014 SHALL handle IDLE as follows: ready=1, w=0, w_valid=0, done=0; on load=1 it SHALL capture data into the shift register, clear the bit counter and go to SHIFT.
REQ-015 SHALL ignore load whenever ready=0; it SHALL not disturb the frame in flight.
REQ-016 SHALL handle SHIFT as follows: w_valid=1 and w=current head bit of the shift register; the register SHALL shift by one bit and the counter SHALL increment by one each cycle.
REQ-017 SHALL go from SHIFT to DONE when the counter reaches WIDTH-1, so exactly WIDTH bits are emitted.
REQ-018 SHALL handle DONE as follows: done=1, w_valid=0, w=0; the FSM SHALL return to IDLE unconditionally on the next cycle.
REQ-019 SHALL meet this latency: load accepted at edge k gives bits in cycles k+1..k+WIDTH, done in cycle k+WIDTH+1, and ready=1 again in cycle k+WIDTH+2.
REQ-020 SHALL keep a register holding the previously emitted bit of the current frame.
REQ-021 SHALL drive z_exp=1 only when w_valid=1, bit index>=1 and w equals the previous bit; otherwise z_exp=0.
REQ-022 SHALL hold z_exp=0 on the first bit of every frame; there SHALL be no history carried between frames.
REQ-023 SHALL size the counter as clog2(WIDTH+1) bits and SHALL not wrap within a frame.
REQ-024 SHALL drive w, w_valid, z_exp, done and ready from registered state only, with no combinational path from load or data.

Reset
REQ-025 SHALL, with reset=1 at an edge, enter IDLE and clear the shift register, counter and previous-bit register.
REQ-026 SHALL produce these values in the cycle after reset: state=001, ready=1, w=0, w_valid=0, z_exp=0, done=0.
REQ-027 SHALL, on reset asserted mid-SHIFT or in DONE, discard the frame in flight with no done pulse.
REQ-028 SHALL give reset priority over load when both are 1 at the same edge; the load SHALL be lost.

Verification
REQ-029 SHALL cover reset: reset=1 for one edge -> state=001, ready=1, w=0, w_valid=0, z_exp=0, done=0.
REQ-030 SHALL cover a basic frame: WIDTH=8, MSB_FIRST=1, load data=8'hB4 -> w=1,0,1,1,0,1,0,0 and z_exp=0,0,0,1,0,0,0,1 with w_valid=1 for 8 cycles; then done=1 for 1 cycle; ready=1 in the following cycle.
REQ-031 SHALL cover load while busy: load data=8'hFF during the 3rd bit of the 8'hB4 frame -> stream unchanged, ready stays 0, no extra frame follows.
REQ-032 SHALL cover reset mid-frame followed by a new frame:
- reset during the 4th bit -> next cycle state=001, w_valid=0, no done pulse.
- then load data=8'h0F -> w=0,0,0,0,1,1,1,1 and z_exp=0,1,1,1,0,1,1,1.
REQ-033 SHALL cover LSB-first order: MSB_FIRST=0, load data=8'h01 -> w=1,0,0,0,0,0,0,0 and z_exp=0,0,1,1,1,1,1,1.
REQ-034 SHALL cover simultaneous load and reset: load=1 and reset=1 at the same edge -> IDLE, w_valid=0 for the following 9 cycles.
